fi_mem_responder: RTL and testbench

Parametrised, multi-channel memory-bus responder for the formal and simulation environments around `frv_core`. It drives the environment side of each req/gnt/recv/ack memory channel (instruction, data, or extra channels) from free environment inputs. It bounds grant stall to guarantee fairness, enforces a minimum response latency, and buffers up to DEPTH outstanding requests per channel. It replaces hand-written per-channel fairness logic and extends it with pipelined outstanding requests and protocol-violation flagging.

---
 rtl/fi_mem_if.sv | 17 +
 rtl/fi_mem_responder.sv | 171 +++++++++++++++++
 tb/tb_fi_mem_responder.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/fi_mem_if.sv
// Core-side memory channel bundle: req/gnt request handshake plus recv/ack response handshake.
// Channel c occupies bit c, or rdata[c*XLEN +: XLEN].
interface fi_mem_if #(
  parameter int NCH  = 2,
  parameter int XLEN = 32
);
  logic [NCH-1:0]      req;
  logic [NCH-1:0]      wen;
  logic [NCH-1:0]      gnt;
  logic [NCH-1:0]      recv;
  logic [NCH-1:0]      ack;
  logic [NCH-1:0]      error;
  logic [NCH*XLEN-1:0] rdata;

  modport master (output req, wen, ack, input gnt, recv, error, rdata);
  modport slave  (input req, wen, ack, output gnt, recv, error, rdata);
endinterface

// File: rtl/fi_mem_responder.sv
// Environment-side responder for NCH independent memory channels: bounded grant stall,
// minimum response latency, DEPTH-deep in-order outstanding queue, sticky protocol flags.
module fi_mem_responder #(
  parameter int NCH       = 2,
  parameter int DEPTH     = 2,
  parameter int LAT       = 0,
  parameter int MAX_STALL = 3,
  parameter int XLEN      = 32
) (
  input  logic                             clock,
  input  logic                             reset,
  fi_mem_if.slave                          bus,
  input  logic [NCH-1:0]                   env_gnt,
  input  logic [NCH-1:0]                   env_err,
  input  logic [NCH*XLEN-1:0]              env_rdata,
  output logic [NCH*$clog2(DEPTH+1)-1:0]   outstanding,
  output logic [NCH-1:0]                   viol
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [NCH-1:0]      gnt_w, recv_w, err_w;
  logic [NCH*XLEN-1:0] rdata_w;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    fi_mem_chan #(.DEPTH(DEPTH), .LAT(LAT), .MAX_STALL(MAX_STALL), .XLEN(XLEN)) u_ch (
      .clock       (clock),
      .reset       (reset),
      .req         (bus.req[c]),
      .wen         (bus.wen[c]),
      .ack         (bus.ack[c]),
      .env_gnt     (env_gnt[c]),
      .env_err     (env_err[c]),
      .env_rdata   (env_rdata[c*XLEN +: XLEN]),
      .gnt         (gnt_w[c]),
      .recv        (recv_w[c]),
      .error       (err_w[c]),
      .rdata       (rdata_w[c*XLEN +: XLEN]),
      .outstanding (outstanding[c*CW +: CW]),
      .viol        (viol[c])
    );
  end

  assign bus.gnt   = gnt_w;
  assign bus.recv  = recv_w;
  assign bus.error = err_w;
  assign bus.rdata = rdata_w;
endmodule

module fi_mem_chan #(
  parameter int DEPTH     = 2,
  parameter int LAT       = 0,
  parameter int MAX_STALL = 3,
  parameter int XLEN      = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         req,
  input  logic                         wen,
  input  logic                         ack,
  input  logic                         env_gnt,
  input  logic                         env_err,
  input  logic [XLEN-1:0]              env_rdata,
  output logic                         gnt,
  output logic                         recv,
  output logic                         error,
  output logic [XLEN-1:0]              rdata,
  output logic [$clog2(DEPTH+1)-1:0]   outstanding,
  output logic                         viol
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int AW = $clog2(LAT + 2);
  localparam int SW = $clog2(MAX_STALL + 2);
  localparam logic [AW-1:0] AGE_MAX   = AW'(LAT);
  localparam logic [SW-1:0] STALL_MAX = SW'(MAX_STALL);
  // An entry is already one cycle old when it lands in the queue (age 0 was its grant cycle).
  localparam logic [AW-1:0] AGE_PUSH  = (LAT > 0) ? AW'(1) : AW'(0);

  logic [DEPTH-1:0]         wen_q, wen_d;
  logic [DEPTH-1:0][AW-1:0] age_q, age_d;
  logic [PW-1:0]            rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [SW-1:0]            stall_q, stall_d;
  logic                     recv_q, recv_d, err_q, err_d, viol_q, viol_d;
  logic [XLEN-1:0]          rdata_q, rdata_d;
  logic                     full, push, head_vld, head_wen, load, pop_fifo, fifo_push;
  logic [AW-1:0]            head_age;

  always_comb begin
    full = (cnt_q == CW'(DEPTH));
    gnt  = req & ~full & (env_gnt | (stall_q == STALL_MAX));
    push = req & gnt;

    // With an empty queue the incoming request is the head, so LAT=0 answers next cycle.
    if (cnt_q != '0) begin
      head_vld = 1'b1;
      head_wen = wen_q[rd_q];
      head_age = age_q[rd_q];
    end else begin
      head_vld = push;
      head_wen = wen;
      head_age = '0;
    end

    load      = head_vld & (head_age == AGE_MAX) & (~recv_q | ack);
    pop_fifo  = load & (cnt_q != '0);
    fifo_push = push & ~(load & (cnt_q == '0));

    wen_d = wen_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    for (int i = 0; i < DEPTH; i++)
      age_d[i] = (age_q[i] == AGE_MAX) ? age_q[i] : age_q[i] + AW'(1);
    if (fifo_push) begin
      wen_d[wr_q] = wen;
      age_d[wr_q] = AGE_PUSH;
      wr_d        = (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + PW'(1);
    end
    if (pop_fifo)
      rd_d = (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + PW'(1);
    cnt_d = cnt_q + CW'(fifo_push) - CW'(pop_fifo);

    recv_d  = recv_q & ~ack;
    err_d   = err_q;
    rdata_d = rdata_q;
    if (load) begin
      recv_d  = 1'b1;
      err_d   = env_err;
      rdata_d = head_wen ? '0 : env_rdata;
    end

    stall_d = stall_q;
    if (~req | gnt)                stall_d = '0;
    else if (stall_q != STALL_MAX) stall_d = stall_q + SW'(1);

    // A nonzero stall count with req low means the core withdrew an ungranted request.
    viol_d = viol_q | (ack & ~recv_q) | (~req & (stall_q != '0));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wen_q   <= '0;
      age_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      stall_q <= '0;
      recv_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      viol_q  <= 1'b0;
    end else begin
      wen_q   <= wen_d;
      age_q   <= age_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      recv_q  <= recv_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      viol_q  <= viol_d;
    end
  end

  assign recv        = recv_q;
  assign error       = err_q;
  assign rdata       = rdata_q;
  assign outstanding = cnt_q + CW'(recv_q);
  assign viol        = viol_q;
endmodule

// File: tb/tb_fi_mem_responder.sv
// Directed bench: per-cycle vector table on a LAT=0 instance, plus hand sequences for
// sticky violations, reset mid-burst and LAT=2 latency on a second instance.
module tb_fi_mem_responder;
  localparam int NCH = 2, XLEN = 32, CW = 2;
  localparam logic [31:0] A1 = 32'h1111_0001, A2 = 32'h1111_0002, A3 = 32'h1111_0003,
                          A4 = 32'h1111_0004, B1 = 32'h2222_0001, B2 = 32'h2222_0002,
                          B3 = 32'h2222_0003, B4 = 32'h2222_0004, C1 = 32'h3333_0001,
                          D0 = 32'h4444_0000, D1 = 32'h4444_0001, E0 = 32'h5555_0000,
                          E1 = 32'h5555_0001, E2 = 32'h5555_0002, E3 = 32'h5555_0003;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  fi_mem_if #(.NCH(NCH), .XLEN(XLEN)) bus_a ();
  fi_mem_if #(.NCH(NCH), .XLEN(XLEN)) bus_b ();
  logic [NCH-1:0]      eg_a, ee_a, eg_b, ee_b, viol_a, viol_b;
  logic [NCH*XLEN-1:0] erd_a, erd_b;
  logic [NCH*CW-1:0]   outs_a, outs_b;

  fi_mem_responder #(.NCH(NCH), .DEPTH(2), .LAT(0), .MAX_STALL(3), .XLEN(XLEN)) dut_a (
    .clock(clock), .reset(reset), .bus(bus_a), .env_gnt(eg_a), .env_err(ee_a),
    .env_rdata(erd_a), .outstanding(outs_a), .viol(viol_a));
  fi_mem_responder #(.NCH(NCH), .DEPTH(2), .LAT(2), .MAX_STALL(3), .XLEN(XLEN)) dut_b (
    .clock(clock), .reset(reset), .bus(bus_b), .env_gnt(eg_b), .env_err(ee_b),
    .env_rdata(erd_b), .outstanding(outs_b), .viol(viol_b));

  typedef struct {
    logic [1:0] req, wen, ack, eg, ee;
    logic [63:0] erd;
    logic [1:0] x_gnt, x_recv, x_err, x_viol;
    logic [63:0] x_rd;
    logic [3:0] x_outs;
  } vec_t;
  vec_t tbl[21];

  int n_run = 0, n_fail = 0;

  function automatic vec_t mk(logic [1:0] rq, logic [1:0] wn, logic [1:0] ak, logic [1:0] g,
                              logic [1:0] e, logic [63:0] rd_in, logic [1:0] xg,
                              logic [1:0] xr, logic [1:0] xe, logic [1:0] xv,
                              logic [63:0] xrd, logic [3:0] xo);
    vec_t v;
    v.req = rq; v.wen = wn; v.ack = ak; v.eg = g; v.ee = e; v.erd = rd_in;
    v.x_gnt = xg; v.x_recv = xr; v.x_err = xe; v.x_viol = xv; v.x_rd = xrd; v.x_outs = xo;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive_a(input logic [1:0] rq, input logic [1:0] wn, input logic [1:0] ak,
                         input logic [1:0] g, input logic [1:0] e, input logic [63:0] rd_in);
    @(negedge clock);
    bus_a.req = rq; bus_a.wen = wn; bus_a.ack = ak; eg_a = g; ee_a = e; erd_a = rd_in;
    #2;
  endtask

  task automatic drive_b(input logic rq, input logic ak, input logic [31:0] rd_in);
    @(negedge clock);
    bus_b.req = {1'b0, rq}; bus_b.ack = {1'b0, ak}; eg_b = 2'b01; erd_b = {32'h0, rd_in};
    #2;
  endtask

  initial begin
    logic [63:0] m;
    bus_a.req = '0; bus_a.wen = '0; bus_a.ack = '0; eg_a = '0; ee_a = '0; erd_a = '0;
    bus_b.req = '0; bus_b.wen = '0; bus_b.ack = '0; eg_b = '0; ee_b = '0; erd_b = '0;

    //               req    wen    ack    eg     ee     erd        gnt    recv   err    viol   rdata      outs
    tbl[0]  = mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 64'h0,      2'b00, 2'b00, 2'b00, 2'b00, 64'h0,      4'd0);
    tbl[1]  = mk(2'b01, 2'b00, 2'b00, 2'b01, 2'b00, {32'h0,A1}, 2'b01, 2'b00, 2'b00, 2'b00, 64'h0,      4'd0);
    tbl[2]  = mk(2'b01, 2'b00, 2'b00, 2'b01, 2'b00, {32'h0,A2}, 2'b01, 2'b01, 2'b00, 2'b00, {32'h0,A1}, 4'd1);
    tbl[3]  = mk(2'b01, 2'b00, 2'b00, 2'b01, 2'b00, {32'h0,A3}, 2'b01, 2'b01, 2'b00, 2'b00, {32'h0,A1}, 4'd2);
    tbl[4]  = mk(2'b01, 2'b00, 2'b00, 2'b01, 2'b00, {32'h0,A4}, 2'b00, 2'b01, 2'b00, 2'b00, {32'h0,A1}, 4'd3);
    tbl[5]  = mk(2'b01, 2'b00, 2'b01, 2'b01, 2'b00, {32'h0,B1}, 2'b00, 2'b01, 2'b00, 2'b00, {32'h0,A1}, 4'd3);
    tbl[6]  = mk(2'b01, 2'b00, 2'b01, 2'b01, 2'b00, {32'h0,B2}, 2'b01, 2'b01, 2'b00, 2'b00, {32'h0,B1}, 4'd2);
    tbl[7]  = mk(2'b00, 2'b00, 2'b01, 2'b01, 2'b00, {32'h0,B3}, 2'b00, 2'b01, 2'b00, 2'b00, {32'h0,B2}, 4'd2);
    tbl[8]  = mk(2'b00, 2'b00, 2'b01, 2'b01, 2'b00, {32'h0,B4}, 2'b00, 2'b01, 2'b00, 2'b00, {32'h0,B3}, 4'd1);
    tbl[9]  = mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 64'h0,      2'b00, 2'b00, 2'b00, 2'b00, 64'h0,      4'd0);
    tbl[10] = mk(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 64'h0,      2'b00, 2'b00, 2'b00, 2'b00, 64'h0,      4'd0);
    tbl[11] = mk(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 64'h0,      2'b00, 2'b00, 2'b00, 2'b00, 64'h0,      4'd0);
    tbl[12] = mk(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 64'h0,      2'b00, 2'b00, 2'b00, 2'b00, 64'h0,      4'd0);
    tbl[13] = mk(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, {32'h0,C1}, 2'b01, 2'b00, 2'b00, 2'b00, 64'h0,      4'd0);
    tbl[14] = mk(2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 64'h0,      2'b00, 2'b01, 2'b00, 2'b00, {32'h0,C1}, 4'd1);
    tbl[15] = mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 64'h0,      2'b00, 2'b00, 2'b00, 2'b00, 64'h0,      4'd0);
    tbl[16] = mk(2'b11, 2'b10, 2'b00, 2'b11, 2'b10, {D1,D0},    2'b11, 2'b00, 2'b00, 2'b00, 64'h0,      4'd0);
    tbl[17] = mk(2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 64'h0,      2'b00, 2'b11, 2'b10, 2'b00, {32'h0,D0}, 4'b0101);
    tbl[18] = mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 64'h0,      2'b00, 2'b00, 2'b00, 2'b00, 64'h0,      4'd0);
    tbl[19] = mk(2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 64'h0,      2'b00, 2'b00, 2'b00, 2'b00, 64'h0,      4'd0);
    tbl[20] = mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 64'h0,      2'b00, 2'b00, 2'b00, 2'b01, 64'h0,      4'd0);

    // Reset state while reset is held
    repeat (2) @(negedge clock);
    #2;
    chk("rst_gnt_a",  {62'h0, bus_a.gnt}, 64'h0);
    chk("rst_recv_a", {62'h0, bus_a.recv}, 64'h0);
    chk("rst_err_a",  {62'h0, bus_a.error}, 64'h0);
    chk("rst_rdata_a", bus_a.rdata, 64'h0);
    chk("rst_outs_a", {60'h0, outs_a}, 64'h0);
    chk("rst_viol_a", {62'h0, viol_a}, 64'h0);
    chk("rst_recv_b", {62'h0, bus_b.recv}, 64'h0);
    chk("rst_outs_b", {60'h0, outs_b}, 64'h0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 21; i++) begin
      drive_a(tbl[i].req, tbl[i].wen, tbl[i].ack, tbl[i].eg, tbl[i].ee, tbl[i].erd);
      m = {{32{tbl[i].x_recv[1]}}, {32{tbl[i].x_recv[0]}}};
      chk($sformatf("v%0d_gnt", i),  {62'h0, bus_a.gnt}, {62'h0, tbl[i].x_gnt});
      chk($sformatf("v%0d_recv", i), {62'h0, bus_a.recv}, {62'h0, tbl[i].x_recv});
      chk($sformatf("v%0d_outs", i), {60'h0, outs_a}, {60'h0, tbl[i].x_outs});
      chk($sformatf("v%0d_viol", i), {62'h0, viol_a}, {62'h0, tbl[i].x_viol});
      if (tbl[i].x_recv != 2'b00) begin
        chk($sformatf("v%0d_err", i), {62'h0, bus_a.error & tbl[i].x_recv}, {62'h0, tbl[i].x_err});
        chk($sformatf("v%0d_rdata", i), bus_a.rdata & m, tbl[i].x_rd & m);
      end
    end

    // Sticky viol[0]; viol[1] must stay clear
    for (int i = 0; i < 100; i++) begin
      drive_a(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 64'h0);
      chk("viol_sticky", {62'h0, viol_a}, 64'h1);
    end

    // Ch1 request withdrawn before grant
    drive_a(2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 64'h0);
    chk("wd_gnt", {62'h0, bus_a.gnt}, 64'h0);
    drive_a(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 64'h0);
    chk("wd_viol_pre", {62'h0, viol_a}, 64'h1);
    drive_a(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 64'h0);
    chk("wd_viol", {62'h0, viol_a}, 64'h3);

    // Reset mid-burst with two pending on ch0
    drive_a(2'b01, 2'b00, 2'b00, 2'b01, 2'b00, {32'h0, A1});
    drive_a(2'b01, 2'b00, 2'b00, 2'b01, 2'b00, {32'h0, A2});
    drive_a(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 64'h0);
    chk("mid_outs_pre", {60'h0, outs_a}, 64'h2);
    @(negedge clock);
    reset = 1'b1;
    #2;
    chk("mid_outs_rst", {60'h0, outs_a}, 64'h0);
    @(negedge clock);
    reset = 1'b0;
    #2;
    chk("mid_outs", {60'h0, outs_a}, 64'h0);
    chk("mid_recv", {62'h0, bus_a.recv}, 64'h0);
    chk("mid_viol", {62'h0, viol_a}, 64'h0);
    for (int i = 0; i < 4; i++) begin
      drive_a(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 64'h0);
      chk("mid_stale_recv", {62'h0, bus_a.recv}, 64'h0);
    end

    // LAT=2: granted in cycle g, recv in g+3 carrying env_rdata from g+2
    drive_b(1'b1, 1'b0, E0);
    chk("lat_gnt", {62'h0, bus_b.gnt}, 64'h1);
    chk("lat_recv_g", {62'h0, bus_b.recv}, 64'h0);
    drive_b(1'b0, 1'b0, E1);
    chk("lat_recv_g1", {62'h0, bus_b.recv}, 64'h0);
    chk("lat_outs_g1", {60'h0, outs_b}, 64'h1);
    drive_b(1'b0, 1'b0, E2);
    chk("lat_recv_g2", {62'h0, bus_b.recv}, 64'h0);
    drive_b(1'b0, 1'b1, E3);
    chk("lat_recv_g3", {62'h0, bus_b.recv}, 64'h1);
    chk("lat_rdata", {32'h0, bus_b.rdata[31:0]}, {32'h0, E2});
    drive_b(1'b0, 1'b0, 32'h0);
    chk("lat_recv_g4", {62'h0, bus_b.recv}, 64'h0);
    chk("lat_viol", {62'h0, viol_b}, 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
